mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_TAGS, default `NUM_MEM_TAGS (15), meaning the count of nonzero memory tags tracked.
REQ-002 SHALL have parameter MAX_LOADS, default 8, meaning the maximum number of outstanding load requests.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the consecutive icache losses before forced icache grant.
REQ-004 clock  in  1  system clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ic_req_valid, ic_req_addr  in  1, 32  icache/prefetcher load request.
REQ-007 ic_req_accepted  out  1  icache request taken by memory this cycle.
REQ-008 dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data  in  1, 2, 32, 64  dcache request; cmd is MEM_LOAD or MEM_STORE.
REQ-009 dc_req_accepted  out  1  dcache request taken by memory this cycle.
REQ-010 grant_tag  out  4  mem_tag of the accepted request; 0 when nothing was accepted.
REQ-011 mem_cmd, mem_addr, mem_data  out  2, 32, 64  request to memory; mem_cmd is MEM_NONE when idle.
REQ-012 mem_tag  in  4  same-cycle memory tag; nonzero means accepted.
REQ-013 mem_resp_tag, mem_resp_data  in  4, 64  memory response; tag 0 means no response.
REQ-014 ic_resp_valid, dc_resp_valid  out  1 each  response routed to its owner.
REQ-015 resp_tag, resp_data  out  4, 64  routed response payload.
REQ-016 loads_outstanding  out  4  current count of outstanding loads.
REQ-017 drop_err  out  1  asserted when a response carried an unowned tag.

Function
REQ-018 Grant SHALL be combinational; at most one requester drives mem_cmd per cycle.
REQ-019 Accept SHALL equal grant & (mem_tag != 0); grant_tag SHALL equal mem_tag on accept, else 0.
REQ-020 Loads SHALL be ineligible for grant while loads_outstanding == MAX_LOADS; stores SHALL remain eligible.
REQ-021 Without the macro, contention SHALL resolve round-robin on a last_grant register that updates only on accept.
REQ-022 An accepted load SHALL write {valid, owner} into the tag table at index mem_tag on the next edge; an accepted store SHALL allocate nothing.
REQ-023 A response with mem_resp_tag nonzero and a valid entry SHALL assert the owner's resp_valid in the same cycle, with resp_tag and resp_data passed through, and SHALL clear the entry at the next edge.
REQ-024 A response with a nonzero tag and no valid entry SHALL assert drop_err for that cycle and assert no resp_valid.
REQ-025 When a response and an allocation hit the same tag in one cycle, the response SHALL route to the old owner and the allocation SHALL win the entry.
REQ-026 loads_outstanding SHALL be incremented by an accepted load and decremented by a valid response; when both occur in one cycle it SHALL stay unchanged.

Reset
REQ-027 Reset SHALL clear the tag table, loads_outstanding, and the starve counter, and SHALL set last_grant to ICACHE so the first contention goes to the dcache.
REQ-028 Responses arriving after a mid-operation reset SHALL be dropped and SHALL flag drop_err.
REQ-029 All valid, accepted, and error outputs SHALL be 0 during reset, and mem_cmd SHALL be MEM_NONE.

Configuration
REQ-030 With MEM_ARB_DCACHE_PRIORITY_EN defined, the dcache SHALL win contention unless the starve counter equals STARVE_LIMIT, in which case the icache SHALL win.
REQ-031 The starve counter SHALL increment when the icache loses contention, and SHALL clear on an icache accept.
REQ-032 Without MEM_ARB_DCACHE_PRIORITY_EN, no starve counter SHALL exist and REQ-021 SHALL apply.

Structure
REQ-033 The MEM_ARB_OWNER enum {OWNER_ICACHE, OWNER_DCACHE} SHALL reside in sys_defs, alongside MEM_TAG, MEM_BLOCK, and MEM_COMMAND.
REQ-034 The tag table SHALL be the sub-module mem_arb_tag_table, with one allocate port, one lookup/free port, and same-tag allocate priority.

Verification
REQ-035 Icache-only load, mem_tag=3, response tag 3 with data 0xDEAD -> ic_req_accepted=1, grant_tag=3; later ic_resp_valid=1 with resp_data=0xDEAD; count goes 0 -> 1 -> 0.
REQ-036 Both requesters valid for 4 cycles, all accepted, round-robin build -> grants in order D, I, D, I.
REQ-037 Priority build, STARVE_LIMIT=4, both requesters always valid -> 4 dcache grants, then 1 icache grant, repeating.
REQ-038 Eight loads outstanding, plus an icache load and a dcache store -> the store is accepted and the load is held until a response arrives.
REQ-039 Response tag 5 with empty table -> drop_err=1 and no resp_valid; response plus new allocation on tag 2 in the same cycle -> old owner served and the new owner recorded.
REQ-040 Reset asserted with 3 loads outstanding, then their responses arrive -> loads_outstanding=0 and drop_err=1 on each response.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-side types plus arbiter-local helpers.
//   sys_defs        : MEM_TAG, MEM_BLOCK, MEM_COMMAND, MEM_ARB_OWNER
//   mem_arbiter_pkg : tag range helper used by the arbiter and its tag table
package sys_defs;

   typedef logic [3:0]  MEM_TAG;
   typedef logic [63:0] MEM_BLOCK;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'h0,
      MEM_LOAD  = 2'h1,
      MEM_STORE = 2'h2
   } MEM_COMMAND;

   typedef enum logic {
      OWNER_ICACHE = 1'b0,
      OWNER_DCACHE = 1'b1
   } MEM_ARB_OWNER;

endpackage

package mem_arbiter_pkg;

   import sys_defs::*;

   // Tag 0 means "no tag"; tags above num_tags are never tracked.
   function automatic logic tag_in_range(input MEM_TAG tag, input int unsigned num_tags);
      return (tag != '0) && (32'(tag) <= num_tags);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus between the two cache requesters, the arbiter and memory.
//   slave  : arbiter view (requests and memory replies in, grants/responses out)
//   master : client/memory view, the mirror image
interface mem_arbiter_if;

   import sys_defs::*;

   logic        ic_req_valid;
   logic [31:0] ic_req_addr;
   logic        ic_req_accepted;

   logic        dc_req_valid;
   MEM_COMMAND  dc_req_cmd;
   logic [31:0] dc_req_addr;
   MEM_BLOCK    dc_req_data;
   logic        dc_req_accepted;

   MEM_TAG      grant_tag;

   MEM_COMMAND  mem_cmd;
   logic [31:0] mem_addr;
   MEM_BLOCK    mem_data;
   MEM_TAG      mem_tag;

   MEM_TAG      mem_resp_tag;
   MEM_BLOCK    mem_resp_data;

   logic        ic_resp_valid;
   logic        dc_resp_valid;
   MEM_TAG      resp_tag;
   MEM_BLOCK    resp_data;

   logic [3:0]  loads_outstanding;
   logic        drop_err;

   modport slave (
      input  ic_req_valid, ic_req_addr,
      input  dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
      input  mem_tag, mem_resp_tag, mem_resp_data,
      output ic_req_accepted, dc_req_accepted, grant_tag,
      output mem_cmd, mem_addr, mem_data,
      output ic_resp_valid, dc_resp_valid, resp_tag, resp_data,
      output loads_outstanding, drop_err
   );

   modport master (
      output ic_req_valid, ic_req_addr,
      output dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
      output mem_tag, mem_resp_tag, mem_resp_data,
      input  ic_req_accepted, dc_req_accepted, grant_tag,
      input  mem_cmd, mem_addr, mem_data,
      input  ic_resp_valid, dc_resp_valid, resp_tag, resp_data,
      input  loads_outstanding, drop_err
   );

endinterface

// File: rtl/mem_arb_tag_table.sv
// Outstanding-load tag table: one {valid, owner} entry per nonzero memory tag.
//   clock, reset  : clock, synchronous active-high reset (clears every entry)
//   alloc_*       : allocate port, writes {1, owner} at alloc_tag on the next edge
//   lookup_tag    : lookup/free port, combinational hit/owner; a hit frees the entry
//   lookup_hit    : lookup_tag names a valid entry
//   lookup_owner  : owner of that entry (old owner even if it is re-allocated this cycle)
// An allocate and a free of the same tag in one cycle leave the entry allocated.
module mem_arb_tag_table
   import sys_defs::*;
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_TAGS = 15
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         alloc_en,
   input  MEM_TAG       alloc_tag,
   input  MEM_ARB_OWNER alloc_owner,
   input  MEM_TAG       lookup_tag,
   output logic         lookup_hit,
   output MEM_ARB_OWNER lookup_owner
);

   // Entry 0 exists only so tags index directly; it is never set.
   logic [NUM_TAGS:0] valid_q, valid_d;
   logic [NUM_TAGS:0] owner_q, owner_d;
   logic              alloc_ok;

   always_comb begin
      alloc_ok     = alloc_en && tag_in_range(alloc_tag, NUM_TAGS);
      lookup_hit   = tag_in_range(lookup_tag, NUM_TAGS) && valid_q[lookup_tag];
      lookup_owner = lookup_hit ? MEM_ARB_OWNER'(owner_q[lookup_tag]) : OWNER_ICACHE;
   end

   always_comb begin
      valid_d = valid_q;
      owner_d = owner_q;
      if (lookup_hit) begin
         valid_d[lookup_tag] = 1'b0;
      end
      // Applied after the free so a same-tag allocate wins the entry.
      if (alloc_ok) begin
         valid_d[alloc_tag] = 1'b1;
         owner_d[alloc_tag] = alloc_owner;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         owner_q <= '0;
      end else begin
         valid_q <= valid_d;
         owner_q <= owner_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache requests onto one memory port and routes tagged
// responses back to whichever cache issued the load.
//   clock, reset : clock, synchronous active-high reset
//   bus          : mem_arbiter_if.slave (requests, grants, memory port, responses,
//                  loads_outstanding, drop_err)
// Build option: MEM_ARB_DCACHE_PRIORITY_EN gives the dcache priority with an
// icache starvation counter; otherwise contention alternates round-robin.
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module mem_arbiter
   import sys_defs::*;
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_TAGS     = `NUM_MEM_TAGS,
   parameter int unsigned MAX_LOADS    = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   if (NUM_TAGS > 15 || MAX_LOADS > 15 || MAX_LOADS == 0 || STARVE_LIMIT == 0)
   begin : g_bad_params
      $error("mem_arbiter: parameter out of range for 4-bit tags/counters");
   end

   localparam logic [3:0] MAX_LOADS_CNT = 4'(MAX_LOADS);

   logic [3:0]   loads_q, loads_d;
   logic         loads_full, dc_is_load;
   logic         ic_elig, dc_elig, ic_wins;
   logic         grant_ic, grant_dc;
   logic         mem_took, accept_ic, accept_dc;
   logic         alloc_en;
   MEM_ARB_OWNER alloc_owner;
   logic         lookup_hit, resp_hit;
   MEM_ARB_OWNER lookup_owner;

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
   localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                contention;
`else
   MEM_ARB_OWNER last_grant_q, last_grant_d;
`endif

   // Grant: loads sit out while the outstanding-load count is at its limit.
   always_comb begin
      loads_full = (loads_q == MAX_LOADS_CNT);
      dc_is_load = (bus.dc_req_cmd == MEM_LOAD);
      ic_elig    = !reset && bus.ic_req_valid && !loads_full;
      dc_elig    = !reset && bus.dc_req_valid && !(dc_is_load && loads_full);
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
      ic_wins    = (starve_q == STARVE_MAX);
`else
      ic_wins    = (last_grant_q == OWNER_DCACHE);
`endif
      grant_ic   = ic_elig && (!dc_elig || ic_wins);
      grant_dc   = dc_elig && !grant_ic;
      mem_took   = (bus.mem_tag != '0);
      accept_ic  = grant_ic && mem_took;
      accept_dc  = grant_dc && mem_took;
      alloc_en   = accept_ic || (accept_dc && dc_is_load);
      alloc_owner = accept_ic ? OWNER_ICACHE : OWNER_DCACHE;
      resp_hit   = !reset && lookup_hit;
   end

   always_comb begin
      bus.mem_cmd  = MEM_NONE;
      bus.mem_addr = '0;
      bus.mem_data = '0;
      if (grant_ic) begin
         bus.mem_cmd  = MEM_LOAD;
         bus.mem_addr = bus.ic_req_addr;
      end else if (grant_dc) begin
         bus.mem_cmd  = bus.dc_req_cmd;
         bus.mem_addr = bus.dc_req_addr;
         bus.mem_data = bus.dc_req_data;
      end
      bus.ic_req_accepted   = accept_ic;
      bus.dc_req_accepted   = accept_dc;
      bus.grant_tag         = (accept_ic || accept_dc) ? bus.mem_tag : '0;
      bus.ic_resp_valid     = resp_hit && (lookup_owner == OWNER_ICACHE);
      bus.dc_resp_valid     = resp_hit && (lookup_owner == OWNER_DCACHE);
      bus.resp_tag          = resp_hit ? bus.mem_resp_tag : '0;
      bus.resp_data         = resp_hit ? bus.mem_resp_data : '0;
      bus.drop_err          = !reset && (bus.mem_resp_tag != '0) && !lookup_hit;
      bus.loads_outstanding = loads_q;
   end

   // A same-cycle allocate and response cancel out.
   always_comb begin
      loads_d = loads_q;
      if (alloc_en && !resp_hit) begin
         loads_d = loads_q + 4'd1;
      end else if (!alloc_en && resp_hit) begin
         loads_d = loads_q - 4'd1;
      end
   end

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
   always_comb begin
      contention = ic_elig && dc_elig;
      starve_d   = starve_q;
      if (accept_ic) begin
         starve_d = '0;
      end else if (contention && grant_dc && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   always_comb begin
      last_grant_d = last_grant_q;
      if (accept_ic) begin
         last_grant_d = OWNER_ICACHE;
      end else if (accept_dc) begin
         last_grant_d = OWNER_DCACHE;
      end
   end

   // Resetting to ICACHE hands the first contention to the dcache.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= OWNER_ICACHE;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         loads_q <= '0;
      end else begin
         loads_q <= loads_d;
      end
   end

   mem_arb_tag_table #(
      .NUM_TAGS (NUM_TAGS)
   ) u_tag_table (
      .clock        (clock),
      .reset        (reset),
      .alloc_en     (alloc_en),
      .alloc_tag    (bus.mem_tag),
      .alloc_owner  (alloc_owner),
      .lookup_tag   (bus.mem_resp_tag),
      .lookup_hit   (lookup_hit),
      .lookup_owner (lookup_owner)
   );

endmodule
